// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared state type, requester index constants and request count for the
// round-robin 4:1 mux arbiter.
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int unsigned NREQ = 4;

  localparam logic [1:0] IDX0 = 2'd0;
  localparam logic [1:0] IDX1 = 2'd1;
  localparam logic [1:0] IDX2 = 2'd2;
  localparam logic [1:0] IDX3 = 2'd3;

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request searching from ptr
// upward, modulo four.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx,
  output logic [3:0] onehot
);

  logic [1:0] k;

  always_comb begin
    found = 1'b0;
    idx   = IDX0;
    k     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = ptr + 2'(i);
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    onehot = found ? (4'b0001 << idx) : '0;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a pipelined 4:1 mux, with a
// bounded hold time and a valid/ID strobe aligned to the mux latency.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       out_valid,
  output logic [1:0] out_id
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  state_t         state;
  logic [1:0]     ptr;
  logic [HW-1:0]  hold_cnt;

  logic           found;
  logic [1:0]     pick_idx;
  logic [3:0]     pick_oh;

  logic [1:0]     cur;
  logic           cur_req;
  logic           others;
  logic           do_grant;
  logic           do_idle;
  logic           do_hold;

  logic                vld_sr [PIPE_LAT];
  logic [1:0]          id_sr  [PIPE_LAT];

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr),
    .found  (found),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // {s1,s0} always holds the current owner while in GRANT.
  assign cur     = {s1, s0};
  assign cur_req = req[cur];
  assign others  = |(req & ~gnt);

  // With ptr = cur+1, a preemptive pick reaches cur last, so it lands on
  // another requester whenever one is pending.
  always_comb begin
    do_grant = 1'b0;
    do_idle  = 1'b0;
    do_hold  = 1'b0;
    unique case (state)
      ST_IDLE:  do_grant = found;
      ST_GRANT: begin
        if (!cur_req) begin
          if (found) do_grant = 1'b1;
          else       do_idle  = 1'b1;
        end else if (hold_cnt < HW'(MAX_HOLD)) begin
          do_hold = 1'b1;
        end else if (others) begin
          do_grant = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      s1       <= 1'b0;
      s0       <= 1'b0;
      busy     <= 1'b0;
    end else if (do_grant) begin
      state    <= ST_GRANT;
      ptr      <= pick_idx + 2'd1;
      hold_cnt <= HW'(1);
      gnt      <= pick_oh;
      {s1, s0} <= pick_idx;
      busy     <= 1'b1;
    end else if (do_idle) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
    end else if (do_hold) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        vld_sr[i] <= 1'b0;
        id_sr[i]  <= '0;
      end
    end else begin
      vld_sr[0] <= |gnt;
      id_sr[0]  <= {s1, s0};
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        id_sr[i]  <= id_sr[i-1];
      end
    end
  end

  assign out_valid = vld_sr[PIPE_LAT-1];
  assign out_id    = id_sr[PIPE_LAT-1];

endmodule
